// File: rtl/nes_decode_pkg.sv
// Shared 6502/65C02 decode types and the pure opcode classification table.
package nes_decode_pkg;

  localparam int BYTE = 8;

  typedef enum logic [3:0] {
    MODE_IMP, MODE_ACC, MODE_IMM, MODE_ZP, MODE_ZPX, MODE_ZPY, MODE_ABS, MODE_ABSX,
    MODE_ABSY, MODE_IND, MODE_INDX, MODE_INDY, MODE_REL, MODE_ZPI, MODE_AIX
  } addressing_mode_t;

  // REG_NONE encodes as zero so an idle/reset packet reads as "no destination".
  typedef enum logic [1:0] {REG_NONE, REG_A, REG_X, REG_Y} reg_id_t;

  typedef enum logic [1:0] {ST_OPC, ST_OP_LO, ST_OP_HI} seq_state_t;

  typedef struct packed {
    addressing_mode_t mode;
    reg_id_t          dst;
    logic [1:0]       len;
    logic             illegal;
  } decode_t;

  typedef struct packed {
    logic [BYTE-1:0]   opcode;
    logic [2*BYTE-1:0] operand;
    addressing_mode_t  mode;
    reg_id_t           dst;
    logic [1:0]        len;
    logic              illegal;
  } instr_pkt_t;

  function automatic logic [1:0] mode_len(input addressing_mode_t m);
    case (m)
      MODE_IMP, MODE_ACC:                           return 2'd1;
      MODE_ABS, MODE_ABSX, MODE_ABSY, MODE_IND,
      MODE_AIX:                                     return 2'd3;
      default:                                      return 2'd2;
    endcase
  endfunction

  // Classify by the aaa/bbb/cc opcode fields; anything outside the documented set is illegal.
  function automatic decode_t decode_opcode(input logic [BYTE-1:0] opcode, input logic cmos_en);
    decode_t    d;
    logic [2:0] aaa;
    logic [2:0] bbb;
    aaa       = opcode[7:5];
    bbb       = opcode[4:2];
    d.mode    = MODE_IMP;
    d.dst     = REG_NONE;
    d.illegal = 1'b0;
    case (opcode[1:0])
      2'b01: begin
        case (bbb)
          3'd0:    d.mode = MODE_INDX;
          3'd1:    d.mode = MODE_ZP;
          3'd2:    d.mode = MODE_IMM;
          3'd3:    d.mode = MODE_ABS;
          3'd4:    d.mode = MODE_INDY;
          3'd5:    d.mode = MODE_ZPX;
          3'd6:    d.mode = MODE_ABSY;
          default: d.mode = MODE_ABSX;
        endcase
        if (opcode == 8'h89) d.illegal = 1'b1;
        if (aaa != 3'd4 && aaa != 3'd6) d.dst = REG_A;
      end
      2'b10: begin
        case (bbb)
          3'd0: begin
            if (aaa == 3'd5) d.mode = MODE_IMM;
            else             d.illegal = 1'b1;
          end
          3'd1: d.mode = MODE_ZP;
          3'd2: d.mode = (aaa < 3'd4) ? MODE_ACC : MODE_IMP;
          3'd3: d.mode = MODE_ABS;
          3'd4: begin
            if (cmos_en) d.mode = MODE_ZPI;
            else         d.illegal = 1'b1;
          end
          3'd5: d.mode = (aaa == 3'd4 || aaa == 3'd5) ? MODE_ZPY : MODE_ZPX;
          3'd6: begin
            if (aaa != 3'd4 && aaa != 3'd5) d.illegal = 1'b1;
          end
          default: begin
            if (aaa == 3'd4)      d.illegal = 1'b1;
            else if (aaa == 3'd5) d.mode = MODE_ABSY;
            else                  d.mode = MODE_ABSX;
          end
        endcase
        if (bbb == 3'd4)                           d.dst = (aaa != 3'd4 && aaa != 3'd6) ? REG_A : REG_NONE;
        else if (aaa == 3'd5)                      d.dst = REG_X;
        else if (bbb == 3'd2 && aaa == 3'd6)       d.dst = REG_X;
        else if (bbb == 3'd2 && aaa != 3'd7)       d.dst = REG_A;
      end
      2'b00: begin
        case (bbb)
          3'd0: begin
            if (aaa == 3'd1)      d.mode = MODE_ABS;
            else if (aaa == 3'd4) d.illegal = 1'b1;
            else if (aaa >= 3'd5) d.mode = MODE_IMM;
          end
          3'd1: begin
            if (aaa == 3'd0 || aaa == 3'd2 || aaa == 3'd3) d.illegal = 1'b1;
            else                                            d.mode = MODE_ZP;
          end
          3'd2: d.mode = MODE_IMP;
          3'd3: begin
            if (aaa == 3'd0)      d.illegal = 1'b1;
            else if (aaa == 3'd3) d.mode = MODE_IND;
            else                  d.mode = MODE_ABS;
          end
          3'd4: d.mode = MODE_REL;
          3'd5: begin
            if (aaa == 3'd4 || aaa == 3'd5) d.mode = MODE_ZPX;
            else                            d.illegal = 1'b1;
          end
          3'd6: d.mode = MODE_IMP;
          default: begin
            if (aaa == 3'd5)                 d.mode = MODE_ABSX;
            else if (aaa == 3'd3 && cmos_en) d.mode = MODE_AIX;
            else                             d.illegal = 1'b1;
          end
        endcase
        if (aaa == 3'd5 && bbb != 3'd4 && bbb != 3'd6)      d.dst = REG_Y;
        else if (bbb == 3'd2 && aaa == 3'd3)                d.dst = REG_A;
        else if (bbb == 3'd2 && (aaa == 3'd4 || aaa == 3'd6)) d.dst = REG_Y;
        else if (bbb == 3'd2 && aaa == 3'd7)                d.dst = REG_X;
        else if (bbb == 3'd6 && aaa == 3'd4)                d.dst = REG_A;
      end
      default: d.illegal = 1'b1;
    endcase
    if (d.illegal) begin
      d.mode = MODE_IMP;
      d.dst  = REG_NONE;
    end
    d.len = mode_len(d.mode);
    return d;
  endfunction

endpackage

// File: rtl/decode_operand_sequencer_instr_queue.sv
// Synchronous FIFO of decoded packets; head is read straight from storage.
module instr_queue
  import nes_decode_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PC_W  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [PC_W-1:0]          push_pc_i,
  input  instr_pkt_t               push_pkt_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [PC_W-1:0]          head_pc_o,
  output instr_pkt_t               head_pkt_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [PC_W-1:0] pc_mem  [DEPTH];
  instr_pkt_t      pkt_mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push, do_pop;

  assign do_push = push_i && (count != CW'(DEPTH)) && !flush_i;
  assign do_pop  = pop_i && (count != '0) && !flush_i;

  // Pointer and occupancy bookkeeping; flush empties the queue like reset.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  // NOTE: storage is deliberately not reset; count/pointers define which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      pc_mem[wr_ptr]  <= push_pc_i;
      pkt_mem[wr_ptr] <= push_pkt_i;
    end
  end

  assign valid_o    = (count != '0);
  assign head_pc_o  = pc_mem[rd_ptr];
  assign head_pkt_o = pkt_mem[rd_ptr];
  assign count_o    = count;

endmodule

// File: rtl/decode_operand_sequencer.sv
// Byte-stream front end: classifies opcodes, gathers operands, queues one packet per instruction.
module decode_operand_sequencer
  import nes_decode_pkg::*;
#(
  parameter int              PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_PC  = PC_W'(16'hFFFC),
  parameter int              OUT_DEPTH = 2,
  parameter bit              CMOS_EN   = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [PC_W-1:0]            flush_pc_i,
  input  logic                       byte_valid_i,
  input  logic [7:0]                 byte_i,
  output logic                       byte_ready_o,
  output logic                       instr_valid_o,
  input  logic                       instr_ready_i,
  output logic [PC_W-1:0]            instr_pc_o,
  output logic [7:0]                 instr_opcode_o,
  output logic [15:0]                instr_operand_o,
  output addressing_mode_t           instr_mode_o,
  output reg_id_t                    instr_reg_o,
  output logic [1:0]                 instr_len_o,
  output logic                       instr_illegal_o,
  output logic [$clog2(OUT_DEPTH):0] count_o
);

  localparam int CW = $clog2(OUT_DEPTH) + 1;

  seq_state_t      state;
  logic [PC_W-1:0] pc, op_pc;
  logic [7:0]      op_code, op_lo;
  decode_t         op_dec, byte_dec;
  logic            accept, push;
  logic [PC_W-1:0] push_pc;
  instr_pkt_t      push_pkt;
  logic            q_valid, show_head;
  logic [PC_W-1:0] head_pc;
  instr_pkt_t      head_pkt;
  logic [CW-1:0]   q_count;

  // Never take a byte unless the queue has room for the packet it might complete.
  assign byte_ready_o = !rst_i && !flush_i && (q_count != CW'(OUT_DEPTH));
  assign accept       = byte_valid_i && byte_ready_o;
  assign byte_dec     = decode_opcode(byte_i, CMOS_EN);

  // Build the packet completed by the byte accepted this cycle, if any.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    push                 = 1'b0;
    push_pc              = op_pc;
    push_pkt.opcode      = op_code;
    push_pkt.operand     = 16'h0000;
    push_pkt.mode        = op_dec.mode;
    push_pkt.dst         = op_dec.dst;
    push_pkt.len         = op_dec.len;
    push_pkt.illegal     = op_dec.illegal;
    case (state)
      ST_OPC: begin
        push             = accept && (byte_dec.len == 2'd1);
        push_pc          = pc;
        push_pkt.opcode  = byte_i;
        push_pkt.mode    = byte_dec.mode;
        push_pkt.dst     = byte_dec.dst;
        push_pkt.len     = byte_dec.len;
        push_pkt.illegal = byte_dec.illegal;
      end
      ST_OP_LO: begin
        push             = accept && (op_dec.len == 2'd2);
        push_pkt.operand = {8'h00, byte_i};
      end
      ST_OP_HI: begin
        push             = accept;
        push_pkt.operand = {byte_i, op_lo};
      end
      default: push = 1'b0;
    endcase
  end

  // Sequencer FSM, pc counter and operand capture; reset, then flush, then handshakes.
  // NOTE: sequential state uses non-blocking assignment so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_OPC;
      pc      <= RESET_PC;
      op_pc   <= '0;
      op_code <= '0;
      op_lo   <= '0;
      op_dec  <= '0;
    end else if (flush_i) begin
      state <= ST_OPC;
      pc    <= flush_pc_i;
    end else if (accept) begin
      pc <= pc + 1'b1;
      case (state)
        ST_OPC: begin
          if (byte_dec.len != 2'd1) begin
            op_pc   <= pc;
            op_code <= byte_i;
            op_dec  <= byte_dec;
            state   <= ST_OP_LO;
          end
        end
        ST_OP_LO: begin
          if (op_dec.len == 2'd2) begin
            state <= ST_OPC;
          end else begin
            op_lo <= byte_i;
            state <= ST_OP_HI;
          end
        end
        default: state <= ST_OPC;
      endcase
    end
  end

  instr_queue #(
    .DEPTH (OUT_DEPTH),
    .PC_W  (PC_W)
  ) u_queue (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .push_i     (push),
    .push_pc_i  (push_pc),
    .push_pkt_i (push_pkt),
    .pop_i      (instr_ready_i),
    .valid_o    (q_valid),
    .head_pc_o  (head_pc),
    .head_pkt_o (head_pkt),
    .count_o    (q_count)
  );

  // Payload reads as zero whenever there is no valid head or reset is held.
  assign show_head       = q_valid && !rst_i;
  assign instr_valid_o   = show_head;
  assign instr_pc_o      = show_head ? head_pc          : '0;
  assign instr_opcode_o  = show_head ? head_pkt.opcode  : 8'h00;
  assign instr_operand_o = show_head ? head_pkt.operand : 16'h0000;
  assign instr_mode_o    = show_head ? head_pkt.mode    : MODE_IMP;
  assign instr_reg_o     = show_head ? head_pkt.dst     : REG_NONE;
  assign instr_len_o     = show_head ? head_pkt.len     : 2'd0;
  assign instr_illegal_o = show_head ? head_pkt.illegal : 1'b0;
  assign count_o         = q_count;

endmodule

// File: tb/tb_decode_operand_sequencer.sv
// Scoreboard bench: directed byte streams into a CMOS_EN=0 and a CMOS_EN=1 instance.
module tb_decode_operand_sequencer;
  import nes_decode_pkg::*;

  typedef struct packed {
    logic [15:0] pc;
    instr_pkt_t  pkt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i = 1'b1, flush_i = 1'b0, byte_valid_i = 1'b0, instr_ready_i = 1'b0;
  logic [15:0] flush_pc_i = 16'h0000;
  logic [7:0]  byte_i = 8'h00;

  logic             byte_ready_0, instr_valid_0, instr_illegal_0;
  logic [15:0]      instr_pc_0, instr_operand_0;
  logic [7:0]       instr_opcode_0;
  addressing_mode_t instr_mode_0;
  reg_id_t          instr_reg_0;
  logic [1:0]       instr_len_0, count_0;

  logic             byte_ready_1, instr_valid_1, instr_illegal_1;
  logic [15:0]      instr_pc_1, instr_operand_1;
  logic [7:0]       instr_opcode_1;
  addressing_mode_t instr_mode_1;
  reg_id_t          instr_reg_1;
  logic [1:0]       instr_len_1, count_1;

  decode_operand_sequencer #(.PC_W(16), .RESET_PC(16'hFFFC), .OUT_DEPTH(2), .CMOS_EN(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .byte_valid_i(byte_valid_i), .byte_i(byte_i), .byte_ready_o(byte_ready_0),
    .instr_valid_o(instr_valid_0), .instr_ready_i(instr_ready_i), .instr_pc_o(instr_pc_0),
    .instr_opcode_o(instr_opcode_0), .instr_operand_o(instr_operand_0), .instr_mode_o(instr_mode_0),
    .instr_reg_o(instr_reg_0), .instr_len_o(instr_len_0), .instr_illegal_o(instr_illegal_0),
    .count_o(count_0)
  );

  decode_operand_sequencer #(.PC_W(16), .RESET_PC(16'hFFFC), .OUT_DEPTH(2), .CMOS_EN(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .byte_valid_i(byte_valid_i), .byte_i(byte_i), .byte_ready_o(byte_ready_1),
    .instr_valid_o(instr_valid_1), .instr_ready_i(instr_ready_i), .instr_pc_o(instr_pc_1),
    .instr_opcode_o(instr_opcode_1), .instr_operand_o(instr_operand_1), .instr_mode_o(instr_mode_1),
    .instr_reg_o(instr_reg_1), .instr_len_o(instr_len_1), .instr_illegal_o(instr_illegal_1),
    .count_o(count_1)
  );

  exp_t exp0[$];
  exp_t exp1[$];
  int   n_vec = 0;
  int   n_mis = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] pc, input logic [7:0] op, input logic [15:0] opnd,
                              input addressing_mode_t m, input reg_id_t r, input logic [1:0] len,
                              input logic ill);
    exp_t e;
    e.pc          = pc;
    e.pkt.opcode  = op;
    e.pkt.operand = opnd;
    e.pkt.mode    = m;
    e.pkt.dst     = r;
    e.pkt.len     = len;
    e.pkt.illegal = ill;
    return e;
  endfunction

  task automatic exp_both(input exp_t e);
    exp0.push_back(e);
    exp1.push_back(e);
  endtask

  // Monitor: every packet popped by the consumer is compared against the scoreboard head.
  always @(negedge clk) begin
    exp_t a0, a1;
    if (!rst_i && !flush_i && instr_ready_i && instr_valid_0) begin
      a0 = mk(instr_pc_0, instr_opcode_0, instr_operand_0, instr_mode_0, instr_reg_0, instr_len_0, instr_illegal_0);
      if (exp0.size() == 0) begin
        n_vec++; n_mis++;
        $display("FAIL dut0 unexpected pkt: got %0h expected none", a0);
      end else check("dut0 pkt", 64'(a0), 64'(exp0.pop_front()));
    end
    if (!rst_i && !flush_i && instr_ready_i && instr_valid_1) begin
      a1 = mk(instr_pc_1, instr_opcode_1, instr_operand_1, instr_mode_1, instr_reg_1, instr_len_1, instr_illegal_1);
      if (exp1.size() == 0) begin
        n_vec++; n_mis++;
        $display("FAIL dut1 unexpected pkt: got %0h expected none", a1);
      end else check("dut1 pkt", 64'(a1), 64'(exp1.pop_front()));
    end
  end

  // All drive tasks start and end just after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    int waited;
    idle(gap);
    byte_valid_i = 1'b1;
    byte_i       = b;
    acc          = 1'b0;
    waited       = 0;
    while (!acc && waited < 50) begin
      @(negedge clk);
      acc = byte_ready_0;
      @(posedge clk); #1;
      waited++;
    end
    byte_valid_i = 1'b0;
    if (!acc) begin
      n_vec++; n_mis++;
      $display("FAIL byte %0h accept: got timeout expected handshake", b);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && k < 50) begin
      idle(1);
      k++;
    end
    idle(2);
  endtask

  task automatic flush_to(input logic [15:0] npc);
    flush_i    = 1'b1;
    flush_pc_i = npc;
    @(negedge clk);
    check("flush byte_ready", 64'(byte_ready_0), 64'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    check("flush count", 64'(count_0), 64'd0);
    check("flush valid", 64'(instr_valid_0), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state.
    instr_ready_i = 1'b1;
    @(negedge clk);
    check("rst byte_ready", 64'(byte_ready_0), 64'd0);
    check("rst valid",      64'(instr_valid_0), 64'd0);
    check("rst count",      64'(count_0), 64'd0);
    check("rst pc",         64'(instr_pc_0), 64'd0);
    check("rst operand",    64'(instr_operand_0), 64'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    // LDA #$42 from reset pc, one-cycle latency after the operand byte.
    exp_both(mk(16'hFFFC, 8'hA9, 16'h0042, MODE_IMM, REG_A, 2'd2, 1'b0));
    send_byte(8'hA9, 0);
    @(negedge clk);
    check("valid before operand", 64'(instr_valid_0), 64'd0);
    @(posedge clk); #1;
    send_byte(8'h42, 0);
    @(negedge clk);
    check("latency valid", 64'(instr_valid_0), 64'd1);
    check("latency count", 64'(count_0), 64'd1);
    @(posedge clk); #1;
    drain();

    // Reset again; LDA abs with gaps, then pc wrap FFFF -> 0000.
    rst_i = 1'b1;
    idle(2);
    rst_i = 1'b0;
    exp_both(mk(16'hFFFC, 8'hAD, 16'h1234, MODE_ABS, REG_A, 2'd3, 1'b0));
    exp_both(mk(16'hFFFF, 8'hEA, 16'h0000, MODE_IMP, REG_NONE, 2'd1, 1'b0));
    exp_both(mk(16'h0000, 8'hEA, 16'h0000, MODE_IMP, REG_NONE, 2'd1, 1'b0));
    send_byte(8'hAD, 3);
    send_byte(8'h34, 3);
    send_byte(8'h12, 3);
    send_byte(8'hEA, 0);
    send_byte(8'hEA, 0);
    drain();

    // Back-pressure: queue fills after two NOPs, third byte stalls, then all emerge in order.
    instr_ready_i = 1'b0;
    exp_both(mk(16'h0001, 8'hEA, 16'h0000, MODE_IMP, REG_NONE, 2'd1, 1'b0));
    exp_both(mk(16'h0002, 8'hEA, 16'h0000, MODE_IMP, REG_NONE, 2'd1, 1'b0));
    exp_both(mk(16'h0003, 8'hEA, 16'h0000, MODE_IMP, REG_NONE, 2'd1, 1'b0));
    send_byte(8'hEA, 0);
    send_byte(8'hEA, 0);
    byte_valid_i = 1'b1;
    byte_i       = 8'hEA;
    repeat (3) begin
      @(negedge clk);
      check("full byte_ready dut0", 64'(byte_ready_0), 64'd0);
      check("full byte_ready dut1", 64'(byte_ready_1), 64'd0);
    end
    check("full count", 64'(count_0), 64'd2);
    @(posedge clk); #1;
    instr_ready_i = 1'b1;
    send_byte(8'hEA, 0);
    drain();

    // Pop and final operand byte in the same cycle: count holds, head advances.
    instr_ready_i = 1'b0;
    exp_both(mk(16'h0004, 8'hEA, 16'h0000, MODE_IMP, REG_NONE, 2'd1, 1'b0));
    exp_both(mk(16'h0005, 8'hA9, 16'h0007, MODE_IMM, REG_A, 2'd2, 1'b0));
    send_byte(8'hEA, 0);
    send_byte(8'hA9, 0);
    byte_valid_i  = 1'b1;
    byte_i        = 8'h07;
    instr_ready_i = 1'b1;
    @(negedge clk);
    check("pop+push byte_ready", 64'(byte_ready_0), 64'd1);
    @(posedge clk); #1;
    byte_valid_i  = 1'b0;
    instr_ready_i = 1'b0;
    @(negedge clk);
    check("pop+push count", 64'(count_0), 64'd1);
    check("pop+push head pc", 64'(instr_pc_0), 64'h0005);
    @(posedge clk); #1;
    instr_ready_i = 1'b1;
    drain();

    // Flush mid-instruction discards the partial LDA abs.
    send_byte(8'hAD, 0);
    send_byte(8'h34, 0);
    flush_to(16'h8000);
    exp_both(mk(16'h8000, 8'hA9, 16'h0001, MODE_IMM, REG_A, 2'd2, 1'b0));
    send_byte(8'hA9, 0);
    send_byte(8'h01, 0);
    drain();

    // 0xB2: illegal without CMOS, (zp) with CMOS.
    exp0.push_back(mk(16'h8002, 8'hB2, 16'h0000, MODE_IMP, REG_NONE, 2'd1, 1'b1));
    exp0.push_back(mk(16'h8003, 8'h10, 16'h0005, MODE_REL, REG_NONE, 2'd2, 1'b0));
    exp1.push_back(mk(16'h8002, 8'hB2, 16'h0010, MODE_ZPI, REG_A, 2'd2, 1'b0));
    send_byte(8'hB2, 0);
    send_byte(8'h10, 0);
    send_byte(8'h05, 0);
    drain();
    flush_to(16'h9000);

    // 0x7C: illegal without CMOS (operands become illegal opcodes), JMP (abs,x) with CMOS.
    exp0.push_back(mk(16'h9000, 8'h7C, 16'h0000, MODE_IMP, REG_NONE, 2'd1, 1'b1));
    exp0.push_back(mk(16'h9001, 8'h34, 16'h0000, MODE_IMP, REG_NONE, 2'd1, 1'b1));
    exp0.push_back(mk(16'h9002, 8'h12, 16'h0000, MODE_IMP, REG_NONE, 2'd1, 1'b1));
    exp1.push_back(mk(16'h9000, 8'h7C, 16'h1234, MODE_AIX, REG_NONE, 2'd3, 1'b0));
    send_byte(8'h7C, 0);
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    drain();

    check("dut0 pkts outstanding", 64'(exp0.size()), 64'd0);
    check("dut1 pkts outstanding", 64'(exp1.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
